// File: rtl/fb_write_sched.sv
// Write-port scheduler for the framebuffer: optional clear sweep at frame start, then
// round-robin arbitration of two pixel writers onto the single registered write port.
module fb_write_sched #(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 115200,
    parameter logic [WIDTH-1:0] CLEAR_COLOR = '0,
    // Overridable so a power-of-two DEPTH can still present out-of-range addresses.
    parameter int               ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  clear_en,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [WIDTH-1:0]      fb_d_in,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SERVE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [31:0]           DEPTH_U   = 32'(DEPTH);

    state_t                r_state;
    logic                  r_rr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_fb_we;
    logic [ADDR_WIDTH-1:0] r_fb_addr;
    logic [WIDTH-1:0]      r_fb_d_in;
    logic                  r_clear_done;
    logic                  r_addr_err;

    logic                  w_grant0;
    logic                  w_grant1;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0]      w_sel_data;
    logic                  w_sel_in_range;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_SERVE && !frame_start) begin
            if (req0_valid && (!req1_valid || !r_rr)) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_sel_addr     = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_data     = w_grant1 ? req1_data : req0_data;
    assign w_sel_in_range = 32'(w_sel_addr) < DEPTH_U;
    assign w_cnt_next     = r_cnt + ADDR_WIDTH'(1);

    // NOTE: state uses non-blocking assignments only; the defaults at the top of the
    // clocked branch make fb_we and clear_done single-cycle unless re-asserted below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr         <= 1'b0;
            r_cnt        <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_d_in    <= '0;
            r_clear_done <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_fb_we      <= 1'b0;
            r_clear_done <= 1'b0;
            if (frame_start) begin
                if (clear_en) begin
                    r_state      <= ST_CLEAR;
                    r_cnt        <= '0;
                    r_fb_we      <= 1'b1;
                    r_fb_addr    <= '0;
                    r_fb_d_in    <= CLEAR_COLOR;
                    r_clear_done <= (DEPTH == 1);
                end else begin
                    r_state <= ST_SERVE;
                end
            end else begin
                case (r_state)
                    // r_cnt tracks the address currently presented on fb_addr.
                    ST_CLEAR: begin
                        if (r_cnt == LAST_ADDR) begin
                            r_state <= ST_SERVE;
                        end else begin
                            r_cnt        <= w_cnt_next;
                            r_fb_we      <= 1'b1;
                            r_fb_addr    <= w_cnt_next;
                            r_fb_d_in    <= CLEAR_COLOR;
                            r_clear_done <= (w_cnt_next == LAST_ADDR);
                        end
                    end
                    ST_SERVE: begin
                        if (w_grant0 || w_grant1) begin
                            r_rr <= w_grant0;
                            if (w_sel_in_range) begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= w_sel_addr;
                                r_fb_d_in <= w_sel_data;
                            end else begin
                                r_addr_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_d_in    = r_fb_d_in;
    assign busy       = (r_state == ST_CLEAR);
    assign clear_done = r_clear_done;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: reset, vector table, clear/restart/abort/range/reset sequences,
// then randomized traffic against a behavioural model.
module tb_fb_write_sched;

    localparam int         WIDTH = 4;
    localparam int         DEPTH = 16;
    localparam int         AW    = 5;
    localparam logic [3:0] CC    = 4'hA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start, clear_en;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [3:0]    req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          fb_we, busy, clear_done, addr_err;
    logic [AW-1:0] fb_addr;
    logic [3:0]    fb_d_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_write_sched #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_COLOR(CC), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .clear_en(clear_en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_d_in(fb_d_in),
        .busy(busy), .clear_done(clear_done), .addr_err(addr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic ce,
                         input logic v0, input logic [AW-1:0] a0, input logic [3:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [3:0] d1);
        frame_start = fs; clear_en = ce;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Vector record: inputs for one cycle, combinational readies, write port after the edge.
    typedef struct {
        logic fs, ce, v0; logic [AW-1:0] a0; logic [3:0] d0;
        logic v1; logic [AW-1:0] a1; logic [3:0] d1;
        logic r0, r1, we; logic [AW-1:0] addr; logic [3:0] d;
    } vec_t;

    // Behavioural model: phase 0 idle, 1 clearing, 2 serving.
    int         m_phase, m_pos, m_rr;
    logic       e_we, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [3:0] e_d;

    initial begin
        vec_t vecs[12];
        int   g;

        rst_n = 1'b0;
        idle();
        tick();

        // Reset held with random inputs: every output stays 0.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), 4'($urandom),
                  1'($urandom), AW'($urandom), 4'($urandom));
            #1;
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_outs", {fb_we, fb_addr, fb_d_in, busy, clear_done, addr_err}, 0);
            tick();
        end
        rst_n = 1'b1;
        drive(0, 0, 1, 3, 1, 1, 4, 2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_ready", {req0_ready, req1_ready}, 0);
            tick();
            check("idle_we", fb_we, 0);
            check("idle_busy", busy, 0);
        end

        // Vector table: collision, round-robin, single requesters, frame_start priority.
        vecs[0]  = '{1,0, 1,3,1,   0,0,0,   0,0, 0, 0,0};
        vecs[1]  = '{0,0, 1,3,1,   0,0,0,   1,0, 1, 3,1};
        vecs[2]  = '{0,0, 1,4,2,   1,5,3,   0,1, 1, 5,3};
        vecs[3]  = '{0,0, 1,6,4,   1,7,5,   1,0, 1, 6,4};
        vecs[4]  = '{0,0, 1,8,6,   1,9,7,   0,1, 1, 9,7};
        vecs[5]  = '{0,0, 1,10,8,  1,11,9,  1,0, 1, 10,8};
        vecs[6]  = '{0,0, 0,0,0,   0,0,0,   0,0, 0, 10,8};
        vecs[7]  = '{0,0, 1,12,11, 0,0,0,   1,0, 1, 12,11};
        vecs[8]  = '{0,0, 0,0,0,   1,13,12, 0,1, 1, 13,12};
        vecs[9]  = '{0,0, 0,0,0,   1,14,13, 0,1, 1, 14,13};
        vecs[10] = '{1,0, 1,1,14,  1,2,15,  0,0, 0, 14,13};
        vecs[11] = '{0,0, 1,1,14,  1,2,15,  1,0, 1, 1,14};
        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].fs, vecs[i].ce, vecs[i].v0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("vec%0d_ready", i), {req0_ready, req1_ready}, {vecs[i].r0, vecs[i].r1});
            tick();
            check($sformatf("vec%0d_we", i), fb_we, vecs[i].we);
            check($sformatf("vec%0d_addr", i), fb_addr, vecs[i].addr);
            check($sformatf("vec%0d_data", i), fb_d_in, vecs[i].d);
        end

        // Full clear sweep from reset.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            check("clr_busy", busy, 1);
            check("clr_we", fb_we, 1);
            check("clr_addr", fb_addr, i);
            check("clr_data", fb_d_in, CC);
            check("clr_done", clear_done, (i == DEPTH - 1));
            tick();
        end
        check("clr_end_busy", busy, 0);
        check("clr_end_we", fb_we, 0);
        check("clr_end_done", clear_done, 0);
        drive(0, 0, 1, 2, 3, 0, 0, 0);
        #1;
        check("serve_ready0", req0_ready, 1);
        tick();
        check("serve_write", {fb_we, fb_addr, fb_d_in}, {1'b1, 5'd2, 4'd3});

        // Restart at address 7.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        check("rst7_addr", fb_addr, 7);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            check("restart_addr", {busy, fb_we, fb_addr}, {2'b11, AW'(i)});
            check("restart_done", clear_done, (i == DEPTH - 1));
            tick();
        end
        check("restart_end_busy", busy, 0);

        // Abort at address 3: no clear_done.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("abort_state", {busy, fb_we, clear_done}, 0);
            tick();
        end

        // Out-of-range write dropped, sticky error.
        drive(0, 0, 0, 0, 0, 1, 20, 5);
        #1;
        check("range_ready1", req1_ready, 1);
        tick();
        check("range_we", fb_we, 0);
        check("range_err", addr_err, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < DEPTH + 1; i++) tick();
        check("range_err_clear", addr_err, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 9, 6, 0, 0, 0);
        tick();
        check("range_after_write", {fb_we, fb_addr, fb_d_in}, {1'b1, 5'd9, 4'd6});
        check("range_err_frame", addr_err, 1);

        // Reset during clear at address 5.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("mid_addr5", fb_addr, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {fb_we, busy, clear_done, addr_err}, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 1, 1, 2, 2);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mid_idle_ready", {req0_ready, req1_ready}, 0);
            tick();
            check("mid_idle_outs", {fb_we, busy, clear_done}, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        m_phase = 0; m_pos = 0; m_rr = 0;
        e_we = 0; e_done = 0; e_err = 0; e_addr = 0; e_d = 0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                  1'($urandom), AW'($urandom_range(0, 19)), 4'($urandom),
                  1'($urandom), AW'($urandom_range(0, 19)), 4'($urandom));
            g = -1;
            if (m_phase == 2 && !frame_start) begin
                if (req0_valid && req1_valid) g = m_rr;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            #1;
            check("rnd_ready0", req0_ready, (g == 0));
            check("rnd_ready1", req1_ready, (g == 1));
            e_we = 0;
            e_done = 0;
            if (frame_start) begin
                if (clear_en) begin
                    m_phase = 1; m_pos = 0;
                    e_we = 1; e_addr = 0; e_d = CC; e_done = (DEPTH == 1);
                end else begin
                    m_phase = 2;
                end
            end else if (m_phase == 1) begin
                if (m_pos == DEPTH - 1) begin
                    m_phase = 2;
                end else begin
                    m_pos++;
                    e_we = 1; e_addr = AW'(m_pos); e_d = CC; e_done = (m_pos == DEPTH - 1);
                end
            end else if (g >= 0) begin
                m_rr = 1 - g;
                if ((g == 0 ? req0_addr : req1_addr) < DEPTH) begin
                    e_we = 1;
                    e_addr = (g == 0) ? req0_addr : req1_addr;
                    e_d = (g == 0) ? req0_data : req1_data;
                end else begin
                    e_err = 1;
                end
            end
            tick();
            check("rnd_we", fb_we, e_we);
            if (e_we) check("rnd_wr", {fb_addr, fb_d_in}, {e_addr, e_d});
            check("rnd_busy", busy, (m_phase == 1));
            check("rnd_done", clear_done, e_done);
            check("rnd_err", addr_err, e_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
